icomp_mfa_seq: RTL and testbench

- Block-level sequencer for the index-compression MFA datapath.
- Accepts one data block of programmable length from upstream and streams it into the MFA unit.
- Issues the MFA read after the last element, waits the fixed MFA read latency, then captures the shared value and its count.
- Decides whether the block is worth index-compressing (count >= threshold), holds the result until downstream acknowledges, then releases the MFA unit for the next block.

---
 rtl/icomp_mfa_seq.sv | 208 ++++++++++++++++++++
 tb/tb_icomp_mfa_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icomp_mfa_seq.sv
`default_nettype none
// ============================================================================
// Module   : icomp_mfa_seq
// Purpose  : Block-level sequencer for the index-compression MFA datapath.
//            It streams one block of programmable length into the MFA unit and
//            issues the MFA read. After the read latency it captures the
//            shared value and its count. It then reports a compress decision,
//            holds it until the downstream ack, and releases the MFA unit.
// Revision : 1.0 - initial release
// ============================================================================
module icomp_mfa_seq #(
  parameter int LENGTH     = 256,
  // Matches the datapath package data width.
  parameter int WIDTH_DATA = 8,
  parameter int RD_LAT     = 3,
  parameter int WIDTH_LEN  = $clog2(LENGTH) + 1,
  parameter int WIDTH_CNT  = $clog2(LENGTH) + 2
) (
  input  logic                  clock,
  input  logic                  reset,
  // Block control
  input  logic                  I_Start,
  input  logic [WIDTH_LEN-1:0]  I_Len,
  input  logic [WIDTH_CNT-1:0]  I_Threshold,
  input  logic                  I_Abort,
  // Upstream element stream
  input  logic                  I_Valid,
  input  logic [WIDTH_DATA-1:0] I_Data,
  output logic                  O_Ready,
  // MFA unit interface
  output logic                  O_MFA_En,
  output logic                  O_MFA_Valid,
  output logic [WIDTH_DATA-1:0] O_MFA_Data,
  output logic                  O_MFA_Rd,
  output logic                  O_MFA_Rls,
  input  logic                  I_MFA_Valid,
  input  logic [WIDTH_DATA-1:0] I_MFA_Shared,
  input  logic [WIDTH_CNT-1:0]  I_MFA_Count,
  // Result interface
  input  logic                  I_Ack,
  output logic                  O_Busy,
  output logic                  O_Done,
  output logic                  O_Compress,
  output logic [WIDTH_DATA-1:0] O_SharedData,
  output logic [WIDTH_CNT-1:0]  O_Count
);

  // The wait counter only has to reach RD_LAT-1.
  localparam int WIDTH_WAIT = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [WIDTH_LEN-1:0]  c_LEN_MAX   = WIDTH_LEN'(LENGTH);
  localparam logic [WIDTH_WAIT-1:0] c_WAIT_LAST = WIDTH_WAIT'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_READ    = 3'd2,
    S_WAIT    = 3'd3,
    S_REPORT  = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t                r_state;
  logic [WIDTH_LEN-1:0]  r_len;
  logic [WIDTH_CNT-1:0]  r_thr;
  logic [WIDTH_LEN-1:0]  r_elem;
  logic [WIDTH_WAIT-1:0] r_wait;

  logic                  r_busy;
  logic                  r_en;
  logic                  r_rd;
  logic                  r_rls;
  logic                  r_done;
  logic                  r_compress;
  logic [WIDTH_DATA-1:0] r_shared;
  logic [WIDTH_CNT-1:0]  r_count;

  logic [WIDTH_LEN-1:0]  w_len_clamped;
  logic [WIDTH_LEN-1:0]  w_elem_next;
  logic                  w_ready;

  // Zero and over-range lengths both mean a full block.
  assign w_len_clamped = ((I_Len == '0) || (I_Len > c_LEN_MAX)) ? c_LEN_MAX : I_Len;
  assign w_elem_next   = r_elem + 1'b1;

  // An abort in FEED refuses the element presented in the same cycle.
  assign w_ready = r_en & ~I_Abort;

  // The element path to the MFA unit is combinational. Only accepted elements
  // are marked valid.
  assign O_Ready      = w_ready;
  assign O_MFA_En     = r_en;
  assign O_MFA_Valid  = w_ready & I_Valid;
  assign O_MFA_Data   = r_en ? I_Data : '0;
  assign O_MFA_Rd     = r_rd;
  assign O_MFA_Rls    = r_rls;
  assign O_Busy       = r_busy;
  assign O_Done       = r_done;
  assign O_Compress   = r_compress;
  assign O_SharedData = r_shared;
  assign O_Count      = r_count;

  // Block sequencer: state, counters, registered strobes and captured results.
  always_ff @(posedge clock) begin
    if (reset) begin
      // The MFA unit shares this reset, so no release pulse is needed.
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_thr      <= '0;
      r_elem     <= '0;
      r_wait     <= '0;
      r_busy     <= 1'b0;
      r_en       <= 1'b0;
      r_rd       <= 1'b0;
      r_rls      <= 1'b0;
      r_done     <= 1'b0;
      r_compress <= 1'b0;
      r_shared   <= '0;
      r_count    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (I_Start) begin
            r_len   <= w_len_clamped;
            r_thr   <= I_Threshold;
            r_elem  <= '0;
            r_busy  <= 1'b1;
            r_en    <= 1'b1;
            r_state <= S_FEED;
          end
        end

        S_FEED: begin
          if (I_Abort) begin
            r_en    <= 1'b0;
            r_rls   <= 1'b1;
            r_state <= S_RELEASE;
          end else if (I_Valid) begin
            r_elem <= w_elem_next;
            if (w_elem_next == r_len) begin
              r_en    <= 1'b0;
              r_rd    <= 1'b1;
              r_state <= S_READ;
            end
          end
        end

        S_READ: begin
          r_rd   <= 1'b0;
          r_wait <= '0;
          if (I_Abort) begin
            r_rls   <= 1'b1;
            r_state <= S_RELEASE;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (I_Abort) begin
            r_rls   <= 1'b1;
            r_state <= S_RELEASE;
          end else if (r_wait == c_WAIT_LAST) begin
            // The shared value is captured as-is. The count and the decision
            // only stand when the MFA unit flags its result valid.
            r_shared   <= I_MFA_Shared;
            r_count    <= I_MFA_Valid ? I_MFA_Count : '0;
            r_compress <= I_MFA_Valid & (I_MFA_Count >= r_thr);
            r_done     <= 1'b1;
            r_state    <= S_REPORT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        S_REPORT: begin
          // Abort and ack lead to the same place. Either way the results are
          // cleared so they read 0 during the release cycle.
          if (I_Abort || I_Ack) begin
            r_done     <= 1'b0;
            r_compress <= 1'b0;
            r_shared   <= '0;
            r_count    <= '0;
            r_rls      <= 1'b1;
            r_state    <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          r_rls   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_en    <= 1'b0;
          r_rd    <= 1'b0;
          r_rls   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icomp_mfa_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_icomp_mfa_seq
// Purpose  : Self-checking bench for icomp_mfa_seq. It includes a behavioural
//            MFA unit that computes the most frequent accepted element.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icomp_mfa_seq;

  localparam int LENGTH     = 256;
  localparam int WIDTH_DATA = 8;
  localparam int RD_LAT     = 3;
  localparam int WIDTH_LEN  = 9;
  localparam int WIDTH_CNT  = 10;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  I_Start;
  logic [WIDTH_LEN-1:0]  I_Len;
  logic [WIDTH_CNT-1:0]  I_Threshold;
  logic                  I_Abort;
  logic                  I_Valid;
  logic [WIDTH_DATA-1:0] I_Data;
  logic                  O_Ready;
  logic                  O_MFA_En;
  logic                  O_MFA_Valid;
  logic [WIDTH_DATA-1:0] O_MFA_Data;
  logic                  O_MFA_Rd;
  logic                  O_MFA_Rls;
  logic                  I_MFA_Valid;
  logic [WIDTH_DATA-1:0] I_MFA_Shared;
  logic [WIDTH_CNT-1:0]  I_MFA_Count;
  logic                  I_Ack;
  logic                  O_Busy;
  logic                  O_Done;
  logic                  O_Compress;
  logic [WIDTH_DATA-1:0] O_SharedData;
  logic [WIDTH_CNT-1:0]  O_Count;

  icomp_mfa_seq #(
    .LENGTH(LENGTH), .WIDTH_DATA(WIDTH_DATA), .RD_LAT(RD_LAT),
    .WIDTH_LEN(WIDTH_LEN), .WIDTH_CNT(WIDTH_CNT)
  ) dut (
    .clock(clock), .reset(reset), .I_Start(I_Start), .I_Len(I_Len),
    .I_Threshold(I_Threshold), .I_Abort(I_Abort), .I_Valid(I_Valid),
    .I_Data(I_Data), .O_Ready(O_Ready), .O_MFA_En(O_MFA_En),
    .O_MFA_Valid(O_MFA_Valid), .O_MFA_Data(O_MFA_Data), .O_MFA_Rd(O_MFA_Rd),
    .O_MFA_Rls(O_MFA_Rls), .I_MFA_Valid(I_MFA_Valid),
    .I_MFA_Shared(I_MFA_Shared), .I_MFA_Count(I_MFA_Count), .I_Ack(I_Ack),
    .O_Busy(O_Busy), .O_Done(O_Done), .O_Compress(O_Compress),
    .O_SharedData(O_SharedData), .O_Count(O_Count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Filled by the monitor
  logic [7:0] acc_q[$];
  int rd_cnt = 0, rls_cnt = 0, done_cnt = 0, rd_cyc = 0, mirror_err = 0;
  bit mfa_ok = 1'b1;

  logic [7:0] d[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Most frequent value and its count. Ties go to the smallest value.
  function automatic void mode_of(input logic [7:0] q[$], output logic [7:0] v, output int c);
    int hist[256];
    foreach (hist[k]) hist[k] = 0;
    foreach (q[k]) hist[q[k]]++;
    v = '0;
    c = 0;
    for (int k = 0; k < 256; k++)
      if (hist[k] > c) begin
        c = hist[k];
        v = 8'(k);
      end
  endfunction

  // Monitor and MFA model. Results are valid exactly RD_LAT cycles after Rd.
  // All other cycles carry random junk.
  initial begin
    int cd;
    logic [7:0] sh;
    int ct;
    cd = 0;
    I_MFA_Valid = 1'b0; I_MFA_Shared = '0; I_MFA_Count = '0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        if (I_Valid && O_Ready) acc_q.push_back(I_Data);
        if (O_MFA_Valid !== (I_Valid & O_Ready)) mirror_err++;
        if (O_MFA_Valid === 1'b1 && O_MFA_Data !== I_Data) mirror_err++;
        if (O_Ready === 1'b1 && O_MFA_En !== 1'b1) mirror_err++;
        if (O_MFA_Rd === 1'b1) begin rd_cnt++; rd_cyc = cyc; end
        if (O_MFA_Rls === 1'b1) rls_cnt++;
        if (O_Done === 1'b1) done_cnt++;
      end
      if (reset === 1'b1) cd = 0;
      else if (O_MFA_Rd === 1'b1) cd = RD_LAT + 1;
      else if (cd > 0) cd--;
      if (cd == 1) begin
        mode_of(acc_q, sh, ct);
        I_MFA_Valid = mfa_ok; I_MFA_Shared = sh; I_MFA_Count = WIDTH_CNT'(ct);
      end else begin
        I_MFA_Valid = 1'($urandom_range(1));
        I_MFA_Shared = 8'($urandom);
        I_MFA_Count = WIDTH_CNT'($urandom);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {O_Ready, O_MFA_En, O_MFA_Valid, O_MFA_Rd, O_MFA_Rls,
                         O_Busy, O_Done, O_Compress}, 0);
    chk({tag, "_data"}, {O_MFA_Data, O_SharedData, O_Count}, 0);
  endtask

  task automatic feed(input logic [7:0] q[$], input int gap_pct, input bit restart);
    int i = 0;
    int guard = 0;
    while (i < q.size() && guard < 5000) begin
      guard++;
      I_Ack   = 1'($urandom_range(1));
      I_Start = restart && (guard % 7 == 3);
      if (int'($urandom_range(99)) < gap_pct) begin
        I_Valid = 1'b0; I_Data = 8'($urandom);
      end else begin
        I_Valid = 1'b1; I_Data = q[i]; i++;
      end
      tick();
    end
    I_Valid = 1'b0; I_Start = 1'b0; I_Ack = 1'b0;
    chk("feed_guard", guard < 5000, 1);
  endtask

  task automatic run_block(input string tag, input int len_in, input int thr,
                           input logic [7:0] q[$], input int gap_pct, input bit restart,
                           input bit mfa_valid, input int ack_delay, input bit chk_timing);
    int eff, s_cyc, rls0, rd0, g, bad, done_cyc, ec;
    logic [7:0] ev;
    logic [WIDTH_DATA+WIDTH_CNT:0] snap;
    eff = (len_in == 0 || len_in > LENGTH) ? LENGTH : len_in;
    acc_q.delete();
    mfa_ok = mfa_valid; rd0 = rd_cnt; rls0 = rls_cnt;
    I_Len = WIDTH_LEN'(len_in); I_Threshold = WIDTH_CNT'(thr); I_Start = 1'b1;
    s_cyc = cyc;
    tick();
    I_Start = 1'b0;
    if (restart) begin I_Len = 3; I_Threshold = 0; end
    feed(q, gap_pct, restart);
    // Elements offered after the block is full must be refused.
    I_Valid = 1'b1; I_Data = 8'hA5;
    tick(); tick();
    I_Valid = 1'b0;
    g = 0;
    while (O_Done !== 1'b1 && g < 2000) begin tick(); g++; end
    done_cyc = cyc;
    chk({tag, "_done_timeout"}, g < 2000, 1);
    mode_of(q, ev, ec);
    chk({tag, "_rd_pulses"}, rd_cnt - rd0, 1);
    if (chk_timing) chk({tag, "_rd_cycle"}, rd_cyc - s_cyc, eff + 1);
    chk({tag, "_done_lat"}, done_cyc - rd_cyc, RD_LAT + 1);
    chk({tag, "_acc_count"}, acc_q.size(), eff);
    bad = 0;
    for (int k = 0; k < eff && k < acc_q.size(); k++) if (acc_q[k] !== q[k]) bad++;
    chk({tag, "_acc_data"}, bad, 0);
    chk({tag, "_mirror"}, mirror_err, 0);
    chk({tag, "_shared"}, O_SharedData, ev);
    chk({tag, "_count"}, O_Count, mfa_valid ? ec : 0);
    chk({tag, "_compress"}, O_Compress, (mfa_valid && ec >= thr) ? 1 : 0);
    chk({tag, "_busy_report"}, O_Busy, 1);
    snap = {O_Compress, O_SharedData, O_Count};
    bad = 0;
    repeat (ack_delay) begin
      tick();
      if (O_Done !== 1'b1 || {O_Compress, O_SharedData, O_Count} !== snap) bad++;
    end
    chk({tag, "_hold"}, bad, 0);
    I_Ack = 1'b1;
    tick();
    I_Ack = 1'b0;
    chk({tag, "_rls_pulse"}, O_MFA_Rls, 1);
    chk({tag, "_release_clear"}, {O_Done, O_Compress, O_SharedData, O_Count}, 0);
    chk({tag, "_release_busy"}, O_Busy, 1);
    tick();
    chk({tag, "_idle_busy"}, O_Busy, 0);
    chk({tag, "_rls_count"}, rls_cnt - rls0, 1);
  endtask

  initial begin
    int g, rd0, rls0, done0, n;
    reset = 1'b1; I_Start = 1'b0; I_Len = '0; I_Threshold = '0; I_Abort = 1'b0;
    I_Valid = 1'b1; I_Data = 8'h3C; I_Ack = 1'b0;

    // Reset state, then IDLE ignoring a valid element
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    @(negedge clock);
    chk("idle_ready", O_Ready, 0);
    chk("idle_mfa_valid", O_MFA_Valid, 0);
    chk("idle_busy", O_Busy, 0);
    tick();
    I_Valid = 1'b0;

    // Directed block: Thr 4, 6 and 5 (equality boundary)
    d = '{8'd5, 8'd5, 8'd5, 8'd1, 8'd5, 8'd2, 8'd5, 8'd3};
    run_block("thr4", 8, 4, d, 0, 1'b0, 1'b1, 0, 1'b1);
    run_block("thr6", 8, 6, d, 0, 1'b0, 1'b1, 0, 1'b1);
    run_block("thr5", 8, 5, d, 0, 1'b0, 1'b1, 2, 1'b1);
    // MFA result invalid, with a long ack delay
    run_block("mfa_inv", 8, 4, d, 0, 1'b0, 1'b0, 10, 1'b1);
    // Threshold zero follows the valid flag
    d = '{8'd9, 8'd7, 8'd9};
    run_block("thr0_v", 3, 0, d, 0, 1'b0, 1'b1, 0, 1'b1);
    run_block("thr0_inv", 3, 0, d, 20, 1'b0, 1'b0, 1, 1'b0);

    // Len 0 means a full block. Use gaps and a second Start during FEED.
    d.delete();
    for (int k = 0; k < LENGTH; k++) d.push_back(8'($urandom_range(0, 15)));
    run_block("len0", 0, 20, d, 30, 1'b1, 1'b1, 1, 1'b0);
    // Over-range length is clamped, back-to-back timing
    d.delete();
    for (int k = 0; k < LENGTH; k++) d.push_back(8'($urandom));
    run_block("len300", 300, 3, d, 0, 1'b0, 1'b1, 0, 1'b1);

    // Random short blocks
    for (int b = 0; b < 4; b++) begin
      n = int'($urandom_range(1, 20));
      d.delete();
      for (int k = 0; k < n; k++) d.push_back(8'($urandom_range(0, 3)));
      run_block("rnd", n, int'($urandom_range(0, 7)), d, 25, 1'b0,
                1'($urandom_range(1)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Abort after 3 accepted elements
    acc_q.delete();
    rd0 = rd_cnt; rls0 = rls_cnt; done0 = done_cnt;
    I_Len = 8; I_Threshold = 1; I_Start = 1'b1;
    tick();
    I_Start = 1'b0;
    for (int k = 0; k < 3; k++) begin I_Valid = 1'b1; I_Data = 8'(k + 1); tick(); end
    I_Valid = 1'b1; I_Data = 8'd9; I_Abort = 1'b1;
    @(negedge clock);
    chk("abort_ready", O_Ready, 0);
    chk("abort_mfa_valid", O_MFA_Valid, 0);
    tick();
    I_Abort = 1'b0; I_Valid = 1'b0;
    chk("abort_rls", O_MFA_Rls, 1);
    chk("abort_busy", O_Busy, 1);
    tick();
    chk("abort_idle", O_Busy, 0);
    chk("abort_rls_count", rls_cnt - rls0, 1);
    chk("abort_no_rd", rd_cnt - rd0, 0);
    chk("abort_no_done", done_cnt - done0, 0);
    chk("abort_acc", acc_q.size(), 3);
    d = '{8'd4, 8'd4, 8'd6, 8'd4};
    run_block("after_abort", 4, 3, d, 0, 1'b0, 1'b1, 0, 1'b1);

    // Reset during WAIT
    acc_q.delete();
    mfa_ok = 1'b1; rls0 = rls_cnt; done0 = done_cnt;
    I_Len = 4; I_Threshold = 1; I_Start = 1'b1;
    tick();
    I_Start = 1'b0;
    d = '{8'd1, 8'd2, 8'd3, 8'd4};
    feed(d, 0, 1'b0);
    g = 0;
    while (O_MFA_Rd !== 1'b1 && g < 20) begin tick(); g++; end
    chk("rstw_rd_seen", g < 20, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("rstw");
    repeat (6) tick();
    chk("rstw_no_rls", rls_cnt - rls0, 0);
    chk("rstw_no_done", done_cnt - done0, 0);
    d = '{8'd8, 8'd8, 8'd2, 8'd8, 8'd8};
    run_block("after_rst", 5, 4, d, 0, 1'b0, 1'b1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
